move_exec: RTL and testbench

Move-execution stage of the 8-puzzle search datapath. It sits directly upstream of the 16×64-bit register file and is one of its write-port masters. On a start pulse it takes a board, order and count snapshot, locates the blank by sequential scan, and checks the requested move for legality and no-backtrack. For a legal move it issues three back-to-back register writes: the new board to r1, the extended order to r2, and the incremented count to r3.

---
 rtl/move_exec.sv | 172 +++++++++++++++++
 tb/tb_move_exec.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/move_exec.sv
// Move-execution stage for the 8-puzzle datapath. It finds the blank, checks the requested move,
// and writes the new board, order and count back through the register-file write port.
module move_exec (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  dir,
    input  logic [63:0] brd_in,
    input  logic [63:0] ord_in,
    input  logic [63:0] cnt_in,
    output logic        busy,
    output logic        done,
    output logic        legal,
    output logic        we,
    output logic [3:0]  dst,
    output logic [63:0] data
);

    typedef enum logic [2:0] {StIdle, StFind, StCheck, StWbrd, StWord, StWcnt, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic        legal_q, legal_d;
    logic [1:0]  dir_q;
    logic [63:0] brd_q, ord_q, cnt_q;

    logic        accept;
    logic [3:0]  nbr;
    logic        illegal;
    logic [63:0] new_brd;
    logic        unused_ord_msb;

    // Map a cell index (3*row+col) to its nibble position within the board word.
    function automatic logic [3:0] nib_pos(input logic [3:0] idx);
        case (idx)
            4'd0:    nib_pos = 4'd10;
            4'd1:    nib_pos = 4'd9;
            4'd2:    nib_pos = 4'd8;
            4'd3:    nib_pos = 4'd6;
            4'd4:    nib_pos = 4'd5;
            4'd5:    nib_pos = 4'd4;
            4'd6:    nib_pos = 4'd2;
            4'd7:    nib_pos = 4'd1;
            default: nib_pos = 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] tile(input logic [63:0] brd, input logic [3:0] idx);
        tile = brd[{nib_pos(idx), 2'b00} +: 4];
    endfunction

    assign accept         = (state_q == StIdle) && start;
    assign unused_ord_msb = ^ord_q[63:62];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= 4'd0;
            legal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            legal_q <= legal_d;
        end
    end

    // Snapshot is taken only on acceptance and held for the whole operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dir_q <= 2'd0;
            brd_q <= 64'd0;
            ord_q <= 64'd0;
            cnt_q <= 64'd0;
        end else if (accept) begin
            dir_q <= dir;
            brd_q <= brd_in;
            ord_q <= ord_in;
            cnt_q <= cnt_in;
        end
    end

    always_comb begin
        nbr = idx_q;
        case (dir_q)
            2'd0:    nbr = idx_q - 4'd3;
            2'd1:    nbr = idx_q + 4'd3;
            2'd2:    nbr = idx_q - 4'd1;
            default: nbr = idx_q + 4'd1;
        endcase
    end

    always_comb begin
        illegal = 1'b0;
        case (dir_q)
            2'd0:    illegal = idx_q < 4'd3;
            2'd1:    illegal = idx_q > 4'd5;
            2'd2:    illegal = (idx_q == 4'd0) || (idx_q == 4'd3) || (idx_q == 4'd6);
            default: illegal = (idx_q == 4'd2) || (idx_q == 4'd5) || (idx_q == 4'd8);
        endcase
        // Undoing the previous move is rejected, except on the very first move.
        if ((cnt_q != 64'd0) && (dir_q == (ord_q[1:0] ^ 2'b01))) begin
            illegal = 1'b1;
        end
    end

    always_comb begin
        new_brd = brd_q;
        new_brd[{nib_pos(idx_q), 2'b00} +: 4] = tile(brd_q, nbr);
        new_brd[{nib_pos(nbr), 2'b00} +: 4]   = 4'h9;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        legal_d = legal_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFind;
                    idx_d   = 4'd0;
                    legal_d = 1'b0;
                end
            end
            StFind: begin
                if (tile(brd_q, idx_q) == 4'h9) begin
                    state_d = StCheck;
                end else if (idx_q == 4'd8) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            StCheck: begin
                legal_d = !illegal;
                state_d = illegal ? StDone : StWbrd;
            end
            StWbrd:  state_d = StWord;
            StWord:  state_d = StWcnt;
            StWcnt:  state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy  = state_q != StIdle;
        done  = state_q == StDone;
        legal = (state_q == StDone) && legal_q;
        we    = 1'b0;
        dst   = 4'd0;
        data  = 64'd0;
        case (state_q)
            StWbrd: begin
                we   = 1'b1;
                dst  = 4'd1;
                data = new_brd;
            end
            StWord: begin
                we   = 1'b1;
                dst  = 4'd2;
                data = {ord_q[61:0], dir_q};
            end
            StWcnt: begin
                we   = 1'b1;
                dst  = 4'd3;
                data = cnt_q + 64'd1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_move_exec.sv
// Directed bench for move_exec: hand-computed boards, latencies and write-back values.
module tb_move_exec;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  dir = 2'd0;
    logic [63:0] brd_in = 64'd0;
    logic [63:0] ord_in = 64'd0;
    logic [63:0] cnt_in = 64'd0;
    logic        busy, done, legal, we;
    logic [3:0]  dst;
    logic [63:0] data;

    int n_checks = 0;
    int n_fail = 0;

    move_exec dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .dir    (dir),
        .brd_in (brd_in),
        .ord_in (ord_in),
        .cnt_in (cnt_in),
        .busy   (busy),
        .done   (done),
        .legal  (legal),
        .we     (we),
        .dst    (dst),
        .data   (data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request and watch it to completion; cycles are counted from acceptance (T0).
    task automatic run_op(input string tag, input logic [63:0] b, input logic [63:0] o,
                          input logic [63:0] c, input logic [1:0] d, input int exp_done,
                          input logic exp_legal, input logic [63:0] e1, input logic [63:0] e2,
                          input logic [63:0] e3, input bit poke);
        int          cyc;
        int          nw;
        int          done_cyc;
        int          busy_bad;
        int          overlap;
        logic        got_legal;
        logic [3:0]  w_dst [3];
        logic [63:0] w_data [3];
        int          w_cyc [3];
        logic [63:0] exp_w [3];

        exp_w[0] = e1;
        exp_w[1] = e2;
        exp_w[2] = e3;
        nw = 0;
        done_cyc = -1;
        busy_bad = 0;
        overlap = 0;
        got_legal = 1'b0;
        @(negedge clk);
        start  = 1'b1;
        dir    = d;
        brd_in = b;
        ord_in = o;
        cnt_in = c;
        @(negedge clk);
        start  = 1'b0;
        brd_in = ~b;
        ord_in = ~o;
        cnt_in = ~c;
        dir    = ~d;
        cyc = 1;
        while (cyc <= 40 && done_cyc < 0) begin
            if (!busy) busy_bad++;
            if (we) begin
                if (nw < 3) begin
                    w_dst[nw]  = dst;
                    w_data[nw] = data;
                    w_cyc[nw]  = cyc;
                end
                nw++;
            end
            if (done) begin
                done_cyc  = cyc;
                got_legal = legal;
                if (we) overlap++;
            end
            // A second request while busy must be dropped.
            start = poke && (cyc == 2);
            if (start) brd_in = 64'h0_0000_129_0_345_0_678;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, "_done_cycle"}, done_cyc, exp_done);
        check({tag, "_legal"}, got_legal, exp_legal);
        check({tag, "_busy_through"}, busy_bad, 0);
        check({tag, "_we_at_done"}, overlap, 0);
        check({tag, "_nwrites"}, nw, exp_legal ? 3 : 0);
        if (exp_legal && nw == 3) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("%s_w%0d_dst", tag, i), w_dst[i], i + 1);
                check($sformatf("%s_w%0d_data", tag, i), w_data[i], exp_w[i]);
                check($sformatf("%s_w%0d_cyc", tag, i), w_cyc[i], exp_done - 3 + i);
            end
        end
        check({tag, "_idle_busy"}, busy, 1'b0);
        check({tag, "_idle_done"}, done, 1'b0);
    endtask

    initial begin
        int we_hits;

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_legal", legal, 1'b0);
        check("rst_we", we, 1'b0);
        check("rst_dst", dst, 4'd0);
        check("rst_data", data, 64'd0);
        rst_n = 1'b1;

        run_op("right", 64'h6_0000_123_0_958_0_746, 64'd0, 64'd0, 2'd3, 9, 1'b1,
               64'h6_0000_123_0_598_0_746, 64'd3, 64'd1, 1'b1);
        run_op("left_edge", 64'h6_0000_123_0_958_0_746, 64'd0, 64'd0, 2'd2, 6, 1'b0,
               64'd0, 64'd0, 64'd0, 1'b0);
        run_op("backtrack", 64'h6_0000_123_0_958_0_746, 64'd2, 64'd5, 2'd3, 6, 1'b0,
               64'd0, 64'd0, 64'd0, 1'b0);
        run_op("no_blank", 64'h0_0000_111_0_111_0_111, 64'd0, 64'd0, 2'd0, 10, 1'b0,
               64'd0, 64'd0, 64'd0, 1'b0);
        run_op("down_wrap", 64'h0_0000_912_0_345_0_678, 64'hC000_0000_0000_0001, '1, 2'd1,
               6, 1'b1, 64'h0_0000_312_0_945_0_678, 64'h0000_0000_0000_0005, 64'd0, 1'b0);

        // Reset in the WORD cycle (T7 for blank at index 3) kills the remaining writes.
        @(negedge clk);
        start  = 1'b1;
        dir    = 2'd3;
        brd_in = 64'h6_0000_123_0_958_0_746;
        ord_in = 64'd0;
        cnt_in = 64'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("rst_mid_we", we, 1'b1);
        check("rst_mid_dst", dst, 4'd2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_done", done, 1'b0);
        check("rst_mid_legal", legal, 1'b0);
        check("rst_mid_we_after", we, 1'b0);
        check("rst_mid_dst_after", dst, 4'd0);
        check("rst_mid_data_after", data, 64'd0);
        we_hits = 0;
        repeat (6) begin
            @(negedge clk);
            if (we || busy) we_hits++;
        end
        check("rst_mid_quiet", we_hits, 0);

        run_op("after_rst", 64'h0_0000_912_0_345_0_678, 64'hC000_0000_0000_0001, '1, 2'd1,
               6, 1'b1, 64'h0_0000_312_0_945_0_678, 64'h0000_0000_0000_0005, 64'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
